serial_shifter: RTL
===================

SERIAL_SHIFTER -- requirements
Module: serial_shifter

Interface
REQ-001 SHALL have parameter STEP, default 1: bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1: request to begin an operation; sampled only in IDLE or DONE.
REQ-005 SHALL have port kill, input, 1: abort (pipeline flush); priority over start.
REQ-006 SHALL have port A, input, 32: operand, latched on accepted start.
REQ-007 SHALL have port shamt, input, 5: shift amount, latched on accepted start.
REQ-008 SHALL have port alufn, input, 2: {function7[5], function3[2]}, latched on accepted start; bit1=1 arithmetic right, else bit0=1 logical right, else logical left.
REQ-009 SHALL have port busy, output, 1: high while in SHIFT.
REQ-010 SHALL have port done, output, 1: one-cycle pulse; result valid on out.
REQ-011 SHALL have port out, output, 32: last completed result.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 IDLE: start=1 and kill=0 latches A/shamt/alufn into working, amount and op registers; next state SHIFT if shamt!=0, else DONE.
REQ-014 SHIFT: each cycle shifts working by k = min(STEP, remaining) and subtracts k from remaining; when remaining reaches 0 the next state is DONE.
REQ-015 Arithmetic right shift SHALL fill with bit 31 of the latched A at every step; logical shifts fill with 0.
REQ-016 Alufn=2'b11 SHALL be treated as arithmetic right shift.
REQ-017 Latency: start high in cycle c -> done high in cycle c+1+n, where n = ceil(shamt/STEP); shamt=0 gives done in c+1.
REQ-018 out SHALL update only on the edge entering DONE and then hold that value until the next such edge; it does not change during SHIFT.
REQ-019 DONE: done=1 for exactly this one cycle; the next state is IDLE.
REQ-020 A start in DONE SHALL be accepted with the same rules as in IDLE, giving back-to-back operations with no idle cycle.
REQ-021 start during SHIFT SHALL be ignored and no operand register changes.
REQ-022 kill=1 in SHIFT SHALL force IDLE at the next edge; no done pulse; out unchanged.
REQ-023 kill=1 in IDLE or DONE SHALL block start acceptance; the DONE pulse in progress is still emitted.
REQ-024 Input changes after acceptance SHALL NOT affect the running operation.
REQ-025 The result SHALL equal the combinational equivalent for all A, shamt and alufn, for every legal STEP.

Reset
REQ-026 rst=0 SHALL immediately, without waiting for a clock edge, force state IDLE, busy=0, done=0, out=0, and clear the working, amount and op registers.
REQ-027 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; after release the block accepts start normally.
REQ-028 The first edge after rst rises SHALL be able to accept a start.

Verification (STEP=1 unless stated)
REQ-029 A=0x80000001, shamt=4, alufn=2'b10, start in cycle c -> busy in c+1..c+4, done in c+5, out=0xF8000000.
REQ-030 A=0x00000001, shamt=31, alufn=2'b00 -> done in c+32, out=0x80000000; A=0x80000000, shamt=31, alufn=2'b01 -> out=0x00000001.
REQ-031 shamt=0, A=0x12345678 -> no busy, done in c+1, out=0x12345678.
REQ-032 STEP=4: A=0xFFFF0000, shamt=5, alufn=2'b11 -> 2 SHIFT cycles (4 then 1), done in c+3, out=0xFFFFF800.
REQ-033 kill in c+2 of a shamt=8 operation -> IDLE in c+3, no done, out keeps its previous value; start in DONE with a new operand -> second done exactly 1+n cycles later.
REQ-034 rst pulsed low during SHIFT -> busy, done and out all 0 immediately; a subsequent operation completes correctly.

Source files
------------

// File: rtl/serial_shifter.sv
// Multi-cycle 32-bit shifter: IDLE -> SHIFT (STEP bits per cycle) -> DONE.
// out holds the last completed result and only moves on the edge into DONE.
//
// state | meaning
// IDLE  | waiting for start; out holds last result
// SHIFT | shifting working by min(STEP, remaining) each cycle; busy=1
// DONE  | one-cycle done pulse; a new start may be accepted here
module serial_shifter #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        kill,
    input  logic [31:0] A,
    input  logic [4:0]  shamt,
    input  logic [1:0]  alufn,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] STEP_AMT = 5'(STEP);

    state_t      state, state_nxt;
    logic [31:0] working, working_nxt;
    logic [31:0] shifted;
    logic [31:0] out_nxt;
    logic [4:0]  amount, amount_nxt;
    logic [4:0]  step_k;
    logic [1:0]  op, op_nxt;

    // Bits consumed this cycle: a full step, or whatever is left.
    always_comb begin
        step_k = (amount < STEP_AMT) ? amount : STEP_AMT;
    end

    // One step of the latched operation; arithmetic right keeps bit 31,
    // which is the sign bit of the latched operand at every step.
    always_comb begin
        shifted = working;
        if (op[1]) begin
            shifted = $signed(working) >>> step_k;
        end else if (op[0]) begin
            shifted = working >> step_k;
        end else begin
            shifted = working << step_k;
        end
    end

    // Next-state and datapath decisions; kill dominates start.
    always_comb begin
        state_nxt   = state;
        working_nxt = working;
        amount_nxt  = amount;
        op_nxt      = op;
        out_nxt     = out;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start && !kill) begin
                    working_nxt = A;
                    amount_nxt  = shamt;
                    op_nxt      = alufn;
                    if (shamt == 5'd0) begin
                        state_nxt = DONE;
                        out_nxt   = A;
                    end else begin
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (kill) begin
                    state_nxt = IDLE;
                end else begin
                    working_nxt = shifted;
                    amount_nxt  = amount - step_k;
                    if (amount == step_k) begin
                        state_nxt = DONE;
                        out_nxt   = shifted;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Working, amount, op and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            working <= '0;
            amount  <= '0;
            op      <= '0;
            out     <= '0;
        end else begin
            working <= working_nxt;
            amount  <= amount_nxt;
            op      <= op_nxt;
            out     <= out_nxt;
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule
